mem1: RTL and testbench
=======================

Name: mem1

Overview:
- First memory stage. Sits between EXE and the mem2 stage.
- Latches the EXE→MEM1 bus and computes the data-memory byte enables and aligned store data.
- Issues one data-memory request per load/store and holds it until the memory acknowledges.
- Owns the MEM1→MEM2 pipeline register. Read data returns the cycle after acknowledge, directly to mem2.

Parameters:
- ADDR_W, 32, data-memory address width (low bits of exe_result).
- BUS_IN_W, 108, width of the EXE→MEM1 bus: {mem_control[5:0], exe_result[31:0], st_data[31:0], wb_wdest[4:0], wb_we, pc[31:0]}.
- BUS_OUT_W, 76, width of the MEM1→MEM2 bus: {mem_control[5:0], exe_result[31:0], wb_wdest[4:0], wb_we, pc[31:0]}.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- exe2mem1_bus_i  in  BUS_IN_W  EXE result bus.
- ctl_exe_valid_i  in  1  EXE holds a valid instruction.
- ctl_mem1_allowin_o  out  1  mem1 accepts a new instruction this cycle.
- ctl_mem2_allowin_i  in  1  mem2 can accept this cycle.
- ctl_flush_i  in  1  synchronous pipeline flush.
- dm_req_o  out  1  data-memory request.
- dm_we_o  out  1  1 = write, 0 = read.
- dm_addr_o  out  ADDR_W  access address.
- dm_be_n_o  out  4  active-low byte enables.
- dm_wdata_o  out  32  store data, lane-replicated.
- dm_ack_i  in  1  request accepted this cycle.
- mem12mem2_bus_o  out  BUS_OUT_W  registered bus to mem2.
- ctl_mem2_valid_o  out  1  registered valid to mem2.
- ctl_mem1_dest_o  out  5  wb_wdest gated by stage-occupied.
- ctl_mem1_ls_o  out  1  stage holds a load or store (load-use detection).
- forward_mem12id_data_o  out  32  exe_result of the held instruction.

Behaviour:
- Reset (asynchronous, immediate):
  - state = S_EMPTY; all stage registers = 0.
  - dm_req_o = 0, dm_we_o = 0, dm_be_n_o = 4'hF, ctl_mem2_valid_o = 0, mem12mem2_bus_o = 0.
  - An outstanding request is dropped at once; no ack is expected afterwards.
- mem_control = {inst_load, inst_store, ld_bh_sign, ld_st_size[2:0]}. Size encoding: 4 = byte, 2 = half, 1 = word.
- States:
  - S_EMPTY: no instruction held.
  - S_REQ: load/store held, request pending.
  - S_HOLD: instruction ready, waiting for mem2.
- Accept: accept = ctl_exe_valid_i & ctl_mem1_allowin_o. On accept, latch the bus and go to S_REQ if (load|store), else S_HOLD.
- S_REQ:
  - dm_req_o = ctl_mem2_allowin_i. A request is never raised while mem2 is stalled.
  - Address, we, be_n and wdata stay stable until ack.
- Fire (transfer to mem2): fire = (S_REQ & dm_ack_i & ctl_mem2_allowin_i) | (S_HOLD & ctl_mem2_allowin_i).
  - On fire: mem12mem2_bus_o ← held fields, ctl_mem2_valid_o ← 1.
  - If mem2 allows in and there is no fire: ctl_mem2_valid_o ← 0.
- After fire: next state = accept ? (S_REQ or S_HOLD per the new instruction) : S_EMPTY. Back-to-back is allowed, 1 instruction/cycle peak.
- ctl_mem1_allowin_o = S_EMPTY | fire.
- Latency:
  - Non-memory instruction: 1 cycle from accept to ctl_mem2_valid_o.
  - Memory instruction: 1 + ack-wait cycles. With zero-wait memory (ack on the first request cycle), valid to mem2 in 1 cycle.
- Byte enables and store data, using a = dm_addr_o[1:0]:
  - Byte: be_n = ~(4'b0001 << a); wdata = {4{st_data[7:0]}}.
  - Half: be_n = a[1] ? 4'b0011 : 4'b1100; wdata = {2{st_data[15:0]}}.
  - Word: be_n = 4'b0000; wdata = st_data.
  - Loads: be_n = 4'b0000, we = 0. When no request is active, dm_be_n_o = 4'hF.
- dm_addr_o = exe_result[ADDR_W-1:0], passed unmodified.
- Flush:
  - In S_HOLD, or in S_REQ before ack: stage cleared → S_EMPTY, dm_req_o drops next cycle.
  - If ack and flush coincide: the access completes and is not forwarded (ctl_mem2_valid_o ← 0).
  - Flush takes priority over accept; ctl_mem1_allowin_o stays high.
- ctl_mem1_dest_o = wb_wdest & {5{state != S_EMPTY}}. ctl_mem1_ls_o = (load|store) & occupied.

Optional Feature:
- Macro: MEM1_ALIGN_CHECK_EN.
- Defined:
  - Misalignment means half with a[0] = 1, or word with a ≠ 0.
  - A misaligned access skips S_REQ and goes to S_HOLD with no dm_req_o.
  - The MEM1→MEM2 bus gains a trailing ale bit (BUS_OUT_W + 1) set to 1; mem2 and wb treat it as an exception.
- Undefined: no check; the access is issued with be_n computed from a as above; bus width unchanged.

Test Plan:
- ADD (no ls), exe_result = 0x1234, mem2_allowin = 1 → next cycle ctl_mem2_valid_o = 1 with bus exe_result 0x1234; dm_req_o never asserted.
- SB with addr 0x1003, st_data 0xAB, ack after 2 wait cycles → dm_req_o high 3 cycles, be_n = 4'b0111, wdata = 0xABABABAB, we = 1; allowin low until the ack cycle.
- LW 0x2000 with zero-wait ack, followed by LW 0x2004 back-to-back → two consecutive fire cycles, be_n = 0000, we = 0, valid stays high 2 cycles.
- SH addr 0x12, ack held off while ctl_flush_i pulses → dm_req_o drops next cycle, no ctl_mem2_valid_o, state returns to S_EMPTY.
- LW pending, rst asserted mid-request → dm_req_o = 0 and be_n = F in the same cycle; after release, allowin = 1.
- With MEM1_ALIGN_CHECK_EN: LH addr 0x1 → no dm_req_o, ale = 1 on the mem2 bus one cycle after accept.

Source files
------------

// File: rtl/mem1_if.sv
// Data-memory request/acknowledge bus between mem1 and the data memory.
// Address, write flag, byte enables and store data are held stable until dm_ack.
interface mem1_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be_n;
  logic [31:0]       dm_wdata;
  logic              dm_ack;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_be_n,
    output dm_wdata,
    input  dm_ack
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_be_n,
    input  dm_wdata,
    output dm_ack
  );
endinterface

// File: rtl/mem1.sv
// First memory stage: holds one EXE instruction, issues its data-memory access and feeds mem2.
// Optional MEM1_ALIGN_CHECK_EN flags misaligned half/word accesses with a trailing ale bit instead of issuing them.
module mem1 #(
  parameter int ADDR_W    = 32,
  parameter int BUS_IN_W  = 108,
  parameter int BUS_OUT_W = 76
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_IN_W-1:0]  exe2mem1_bus_i,
  input  logic                 ctl_exe_valid_i,
  output logic                 ctl_mem1_allowin_o,
  input  logic                 ctl_mem2_allowin_i,
  input  logic                 ctl_flush_i,
  mem1_if.master               dm,
`ifdef MEM1_ALIGN_CHECK_EN
  output logic [BUS_OUT_W:0]   mem12mem2_bus_o,
`else
  output logic [BUS_OUT_W-1:0] mem12mem2_bus_o,
`endif
  output logic                 ctl_mem2_valid_o,
  output logic [4:0]           ctl_mem1_dest_o,
  output logic                 ctl_mem1_ls_o,
  output logic [31:0]          forward_mem12id_data_o
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_REQ,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [BUS_IN_W-1:0] held;
  logic [5:0]          h_ctrl;
  logic [31:0]         h_res;
  logic [31:0]         h_st;
  logic [4:0]          h_dest;
  logic                h_wbwe;
  logic [31:0]         h_pc;
  logic                h_load;
  logic                h_store;
  logic                h_ls;
  logic [2:0]          h_size;
  logic [1:0]          h_a;

  logic in_ls;
  logic in_mis;
  logic h_ale;
  logic occupied;
  logic fire_raw;
  logic fire;
  logic accept;

  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign {h_ctrl, h_res, h_st, h_dest, h_wbwe, h_pc} = held;
  assign h_load  = h_ctrl[5];
  assign h_store = h_ctrl[4];
  assign h_size  = h_ctrl[2:0];
  assign h_ls    = h_load | h_store;
  assign h_a     = h_res[1:0];

  assign in_ls = exe2mem1_bus_i[107] | exe2mem1_bus_i[106];

`ifdef MEM1_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
    return ((size == 3'd2) && a[0]) || ((size == 3'd1) && (a != 2'b00));
  endfunction

  assign in_mis = in_ls & misaligned(exe2mem1_bus_i[104:102], exe2mem1_bus_i[71:70]);
  assign h_ale  = h_ls & misaligned(h_size, h_a);
`else
  assign in_mis = 1'b0;
  assign h_ale  = 1'b0;
`endif

  // State register; reset drops any outstanding request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake: flush beats accept, and an ack coinciding with flush completes but is not forwarded.
  always_comb begin
    state_nxt          = state;
    occupied           = (state != S_EMPTY);
    fire_raw           = ((state == S_REQ) & dm.dm_ack & ctl_mem2_allowin_i) |
                         ((state == S_HOLD) & ctl_mem2_allowin_i);
    fire               = fire_raw & ~ctl_flush_i;
    ctl_mem1_allowin_o = (state == S_EMPTY) | fire_raw | ctl_flush_i;
    accept             = ctl_exe_valid_i & ctl_mem1_allowin_o & ~ctl_flush_i;

    if (ctl_flush_i) begin
      state_nxt = S_EMPTY;
    end else if (accept) begin
      state_nxt = (in_ls & ~in_mis) ? S_REQ : S_HOLD;
    end else if (fire) begin
      state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
    end else if (ctl_flush_i) begin
      held <= '0;
    end else if (accept) begin
      held <= exe2mem1_bus_i;
    end
  end

  // MEM1->MEM2 register: valid only clears when mem2 has taken the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_mem2_valid_o <= 1'b0;
      mem12mem2_bus_o  <= '0;
    end else if (ctl_flush_i) begin
      ctl_mem2_valid_o <= 1'b0;
    end else if (fire) begin
      ctl_mem2_valid_o <= 1'b1;
`ifdef MEM1_ALIGN_CHECK_EN
      mem12mem2_bus_o  <= {h_ctrl, h_res, h_dest, h_wbwe, h_pc, h_ale};
`else
      mem12mem2_bus_o  <= {h_ctrl, h_res, h_dest, h_wbwe, h_pc};
`endif
    end else if (ctl_mem2_allowin_i) begin
      ctl_mem2_valid_o <= 1'b0;
    end
  end

  always_comb begin
    be_calc    = 4'b0000;
    wdata_calc = h_st;
    case (h_size)
      3'd4: begin
        be_calc    = ~(4'b0001 << h_a);
        wdata_calc = {4{h_st[7:0]}};
      end
      3'd2: begin
        be_calc    = h_a[1] ? 4'b0011 : 4'b1100;
        wdata_calc = {2{h_st[15:0]}};
      end
      default: ;
    endcase
    if (!h_store) begin
      be_calc = 4'b0000;
    end
  end

  // Request is withheld while mem2 stalls so the returning data always has a home.
  assign dm.dm_req   = (state == S_REQ) & ctl_mem2_allowin_i;
  assign dm.dm_we    = (state == S_REQ) & h_store;
  assign dm.dm_addr  = h_res[ADDR_W-1:0];
  assign dm.dm_be_n  = (state == S_REQ) ? be_calc : 4'hF;
  assign dm.dm_wdata = wdata_calc;

  assign ctl_mem1_dest_o        = h_dest & {5{occupied}};
  assign ctl_mem1_ls_o          = h_ls & occupied;
  assign forward_mem12id_data_o = h_res;

endmodule

// File: tb/tb_mem1.sv
// Directed self-checking bench for mem1: reset, non-memory pass-through, stores, loads,
// mem2 stall, flush and mid-request reset, plus the ale flag when MEM1_ALIGN_CHECK_EN is set.
module tb_mem1;

`ifdef MEM1_ALIGN_CHECK_EN
  localparam int OW = 77;
`else
  localparam int OW = 76;
`endif

  localparam logic [5:0] C_ADD = 6'b000000;
  localparam logic [5:0] C_LW  = 6'b100001;
  localparam logic [5:0] C_SB  = 6'b010100;
  localparam logic [5:0] C_SH  = 6'b010010;
  localparam logic [5:0] C_LH  = 6'b101010;

  logic          clk = 1'b0;
  logic          rst;
  logic [107:0]  bus_in;
  logic          exe_valid;
  logic          mem1_allowin;
  logic          mem2_allowin;
  logic          flush;
  logic [OW-1:0] bus_out;
  logic          mem2_valid;
  logic [4:0]    mem1_dest;
  logic          mem1_ls;
  logic [31:0]   fwd_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem1_if #(.ADDR_W(32)) dm_bus ();

  mem1 #(.ADDR_W(32), .BUS_IN_W(108), .BUS_OUT_W(76)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .exe2mem1_bus_i         (bus_in),
    .ctl_exe_valid_i        (exe_valid),
    .ctl_mem1_allowin_o     (mem1_allowin),
    .ctl_mem2_allowin_i     (mem2_allowin),
    .ctl_flush_i            (flush),
    .dm                     (dm_bus),
    .mem12mem2_bus_o        (bus_out),
    .ctl_mem2_valid_o       (mem2_valid),
    .ctl_mem1_dest_o        (mem1_dest),
    .ctl_mem1_ls_o          (mem1_ls),
    .forward_mem12id_data_o (fwd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [107:0] mk_in(input logic [5:0] c, input logic [31:0] r,
                                         input logic [31:0] s, input logic [4:0] d,
                                         input logic w, input logic [31:0] p);
    return {c, r, s, d, w, p};
  endfunction

  function automatic logic [75:0] mk_out(input logic [5:0] c, input logic [31:0] r,
                                         input logic [4:0] d, input logic w,
                                         input logic [31:0] p);
    return {c, r, d, w, p};
  endfunction

  function automatic logic [OW-1:0] pad(input logic [75:0] b);
`ifdef MEM1_ALIGN_CHECK_EN
    return {b, 1'b0};
`else
    return b;
`endif
  endfunction

  task test_reset;
    rst = 1'b1; bus_in = '0; exe_valid = 1'b0; mem2_allowin = 1'b1; flush = 1'b0;
    dm_bus.dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem1_allowin !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_allowin got %b want 1", mem1_allowin); end
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req got %b want 0", dm_bus.dm_req); end
    n_cmp++; if (dm_bus.dm_be_n !== 4'hF) begin n_bad++; $display("[TB] FAIL reset_be_n got %h want F", dm_bus.dm_be_n); end
    n_cmp++; if (dm_bus.dm_we !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_we got %b want 0", dm_bus.dm_we); end
    n_cmp++; if (mem2_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid got %b want 0", mem2_valid); end
    n_cmp++; if (bus_out !== '0) begin n_bad++; $display("[TB] FAIL reset_bus got %h want 0", bus_out); end
    n_cmp++; if (mem1_dest !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_dest got %h want 0", mem1_dest); end
    n_cmp++; if (mem1_ls !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ls got %b want 0", mem1_ls); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task test_non_mem;
    @(negedge clk);
    bus_in = mk_in(C_ADD, 32'h1234, 32'hDEADBEEF, 5'd7, 1'b1, 32'h100);
    exe_valid = 1'b1;
    #1;
    n_cmp++; if (mem1_allowin !== 1'b1) begin n_bad++; $display("[TB] FAIL add_allowin got %b want 1", mem1_allowin); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL add_valid_early got %b want 0", mem2_valid); end
    n_cmp++; if (mem1_dest !== 5'd7) begin n_bad++; $display("[TB] FAIL add_dest got %h want 7", mem1_dest); end
    n_cmp++; if (fwd_data !== 32'h1234) begin n_bad++; $display("[TB] FAIL add_fwd got %h want 1234", fwd_data); end
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL add_req got %b want 0", dm_bus.dm_req); end
    @(negedge clk);
    exe_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL add_valid got %b want 1", mem2_valid); end
    n_cmp++; if (bus_out !== pad(mk_out(C_ADD, 32'h1234, 5'd7, 1'b1, 32'h100))) begin n_bad++; $display("[TB] FAIL add_bus got %h want %h", bus_out, pad(mk_out(C_ADD, 32'h1234, 5'd7, 1'b1, 32'h100))); end
    n_cmp++; if (mem1_dest !== 5'd0) begin n_bad++; $display("[TB] FAIL add_dest_empty got %h want 0", mem1_dest); end
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL add_req_after got %b want 0", dm_bus.dm_req); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL add_valid_drop got %b want 0", mem2_valid); end
  endtask

  task test_store_byte;
    logic exp_a;
    @(negedge clk);
    bus_in = mk_in(C_SB, 32'h1003, 32'h000000AB, 5'd0, 1'b0, 32'h200);
    exe_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mem1_ls !== 1'b1) begin n_bad++; $display("[TB] FAIL sb_ls got %b want 1", mem1_ls); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exe_valid = 1'b0;
      dm_bus.dm_ack = (i == 2);
      exp_a = (i == 2);
      #1;
      n_cmp++; if (dm_bus.dm_req !== 1'b1) begin n_bad++; $display("[TB] FAIL sb_req[%0d] got %b want 1", i, dm_bus.dm_req); end
      n_cmp++; if (dm_bus.dm_be_n !== 4'b0111) begin n_bad++; $display("[TB] FAIL sb_be_n[%0d] got %b want 0111", i, dm_bus.dm_be_n); end
      n_cmp++; if (dm_bus.dm_wdata !== 32'hABABABAB) begin n_bad++; $display("[TB] FAIL sb_wdata[%0d] got %h want ABABABAB", i, dm_bus.dm_wdata); end
      n_cmp++; if (dm_bus.dm_we !== 1'b1) begin n_bad++; $display("[TB] FAIL sb_we[%0d] got %b want 1", i, dm_bus.dm_we); end
      n_cmp++; if (dm_bus.dm_addr !== 32'h1003) begin n_bad++; $display("[TB] FAIL sb_addr[%0d] got %h want 1003", i, dm_bus.dm_addr); end
      n_cmp++; if (mem1_allowin !== exp_a) begin n_bad++; $display("[TB] FAIL sb_allowin[%0d] got %b want %b", i, mem1_allowin, exp_a); end
    end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL sb_valid got %b want 1", mem2_valid); end
    n_cmp++; if (bus_out !== pad(mk_out(C_SB, 32'h1003, 5'd0, 1'b0, 32'h200))) begin n_bad++; $display("[TB] FAIL sb_bus got %h want %h", bus_out, pad(mk_out(C_SB, 32'h1003, 5'd0, 1'b0, 32'h200))); end
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL sb_req_end got %b want 0", dm_bus.dm_req); end
    n_cmp++; if (dm_bus.dm_be_n !== 4'hF) begin n_bad++; $display("[TB] FAIL sb_be_n_end got %h want F", dm_bus.dm_be_n); end
  endtask

  task test_back_to_back;
    @(negedge clk);
    bus_in = mk_in(C_LW, 32'h2000, 32'h0, 5'd3, 1'b1, 32'h300);
    exe_valid = 1'b1;
    @(negedge clk);
    bus_in = mk_in(C_LW, 32'h2004, 32'h0, 5'd4, 1'b1, 32'h304);
    dm_bus.dm_ack = 1'b1;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b1) begin n_bad++; $display("[TB] FAIL lw0_req got %b want 1", dm_bus.dm_req); end
    n_cmp++; if (dm_bus.dm_be_n !== 4'b0000) begin n_bad++; $display("[TB] FAIL lw0_be_n got %b want 0000", dm_bus.dm_be_n); end
    n_cmp++; if (dm_bus.dm_we !== 1'b0) begin n_bad++; $display("[TB] FAIL lw0_we got %b want 0", dm_bus.dm_we); end
    n_cmp++; if (dm_bus.dm_addr !== 32'h2000) begin n_bad++; $display("[TB] FAIL lw0_addr got %h want 2000", dm_bus.dm_addr); end
    n_cmp++; if (mem1_allowin !== 1'b1) begin n_bad++; $display("[TB] FAIL lw0_allowin got %b want 1", mem1_allowin); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL lw0_valid got %b want 1", mem2_valid); end
    n_cmp++; if (bus_out !== pad(mk_out(C_LW, 32'h2000, 5'd3, 1'b1, 32'h300))) begin n_bad++; $display("[TB] FAIL lw0_bus got %h want %h", bus_out, pad(mk_out(C_LW, 32'h2000, 5'd3, 1'b1, 32'h300))); end
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b1) begin n_bad++; $display("[TB] FAIL lw1_req got %b want 1", dm_bus.dm_req); end
    n_cmp++; if (dm_bus.dm_addr !== 32'h2004) begin n_bad++; $display("[TB] FAIL lw1_addr got %h want 2004", dm_bus.dm_addr); end
    n_cmp++; if (mem1_dest !== 5'd4) begin n_bad++; $display("[TB] FAIL lw1_dest got %h want 4", mem1_dest); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL lw1_valid got %b want 1", mem2_valid); end
    n_cmp++; if (bus_out !== pad(mk_out(C_LW, 32'h2004, 5'd4, 1'b1, 32'h304))) begin n_bad++; $display("[TB] FAIL lw1_bus got %h want %h", bus_out, pad(mk_out(C_LW, 32'h2004, 5'd4, 1'b1, 32'h304))); end
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_req_end got %b want 0", dm_bus.dm_req); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_valid_drop got %b want 0", mem2_valid); end
  endtask

  task test_mem2_stall;
    @(negedge clk);
    bus_in = mk_in(C_LW, 32'h40, 32'h0, 5'd9, 1'b1, 32'h600);
    exe_valid = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    mem2_allowin = 1'b0;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_req got %b want 0", dm_bus.dm_req); end
    n_cmp++; if (mem1_allowin !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_allowin got %b want 0", mem1_allowin); end
    n_cmp++; if (mem1_ls !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_ls got %b want 1", mem1_ls); end
    @(negedge clk);
    mem2_allowin = 1'b1;
    dm_bus.dm_ack = 1'b1;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_req_go got %b want 1", dm_bus.dm_req); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_valid got %b want 1", mem2_valid); end
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
  endtask

  task test_flush;
    @(negedge clk);
    bus_in = mk_in(C_SH, 32'h12, 32'h00005678, 5'd2, 1'b0, 32'h400);
    exe_valid = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b1) begin n_bad++; $display("[TB] FAIL sh_req got %b want 1", dm_bus.dm_req); end
    n_cmp++; if (dm_bus.dm_be_n !== 4'b0011) begin n_bad++; $display("[TB] FAIL sh_be_n got %b want 0011", dm_bus.dm_be_n); end
    n_cmp++; if (dm_bus.dm_wdata !== 32'h56785678) begin n_bad++; $display("[TB] FAIL sh_wdata got %h want 56785678", dm_bus.dm_wdata); end
    @(negedge clk);
    flush = 1'b1;
    bus_in = mk_in(C_ADD, 32'h77, 32'h0, 5'd5, 1'b1, 32'h404);
    exe_valid = 1'b1;
    #1;
    n_cmp++; if (mem1_allowin !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_allowin got %b want 1", mem1_allowin); end
    @(posedge clk); #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_req got %b want 0", dm_bus.dm_req); end
    n_cmp++; if (mem2_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_valid got %b want 0", mem2_valid); end
    n_cmp++; if (mem1_dest !== 5'd0) begin n_bad++; $display("[TB] FAIL flush_dest got %h want 0", mem1_dest); end
    n_cmp++; if (mem1_ls !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_ls got %b want 0", mem1_ls); end
    @(negedge clk);
    flush = 1'b0;
    exe_valid = 1'b0;
    #1;
    n_cmp++; if (mem1_allowin !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_allowin_after got %b want 1", mem1_allowin); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_valid_after got %b want 0", mem2_valid); end
  endtask

  task test_reset_mid;
    @(negedge clk);
    bus_in = mk_in(C_LW, 32'h3000, 32'h0, 5'd8, 1'b1, 32'h700);
    exe_valid = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b1) begin n_bad++; $display("[TB] FAIL rstmid_req_before got %b want 1", dm_bus.dm_req); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rstmid_req got %b want 0", dm_bus.dm_req); end
    n_cmp++; if (dm_bus.dm_be_n !== 4'hF) begin n_bad++; $display("[TB] FAIL rstmid_be_n got %h want F", dm_bus.dm_be_n); end
    n_cmp++; if (mem1_ls !== 1'b0) begin n_bad++; $display("[TB] FAIL rstmid_ls got %b want 0", mem1_ls); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (mem1_allowin !== 1'b1) begin n_bad++; $display("[TB] FAIL rstmid_allowin got %b want 1", mem1_allowin); end
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rstmid_req_after got %b want 0", dm_bus.dm_req); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rstmid_valid got %b want 0", mem2_valid); end
  endtask

`ifdef MEM1_ALIGN_CHECK_EN
  task test_align;
    @(negedge clk);
    bus_in = mk_in(C_LH, 32'h1, 32'h0, 5'd6, 1'b1, 32'h500);
    exe_valid = 1'b1;
    @(negedge clk);
    exe_valid = 1'b0;
    #1;
    n_cmp++; if (dm_bus.dm_req !== 1'b0) begin n_bad++; $display("[TB] FAIL ale_req got %b want 0", dm_bus.dm_req); end
    n_cmp++; if (dm_bus.dm_be_n !== 4'hF) begin n_bad++; $display("[TB] FAIL ale_be_n got %h want F", dm_bus.dm_be_n); end
    @(posedge clk); #1;
    n_cmp++; if (mem2_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ale_valid got %b want 1", mem2_valid); end
    n_cmp++; if (bus_out !== {mk_out(C_LH, 32'h1, 5'd6, 1'b1, 32'h500), 1'b1}) begin n_bad++; $display("[TB] FAIL ale_bus got %h want %h", bus_out, {mk_out(C_LH, 32'h1, 5'd6, 1'b1, 32'h500), 1'b1}); end
  endtask
`endif

  initial begin
    $display("[TB] tb_mem1 start");
    test_reset;
    test_non_mem;
    test_store_byte;
    test_back_to_back;
    test_mem2_stall;
    test_flush;
    test_reset_mid;
`ifdef MEM1_ALIGN_CHECK_EN
    test_align;
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
